// File: rtl/jtopl_wr_ctrl.sv
// jtopl_wr_ctrl: decodes CPU register writes into a slot target and one update strobe,
// holding them for HOLD cen ticks so the slot sequencer can pass the target.
module jtopl_wr_ctrl #(
  parameter int HOLD = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen_i,
  input  logic       cs_n_i,
  input  logic       wr_n_i,
  input  logic       addr_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       write_o,
  output logic [1:0] sel_group_o,
  output logic [2:0] sel_sub_o,
  output logic       up_mult_o,
  output logic       up_ksl_tl_o,
  output logic       up_ar_dr_o,
  output logic       up_sl_rr_o,
  output logic       up_fnum_o,
  output logic       up_fbcon_o,
  output logic [7:0] latch_fnum_o,
  output logic       busy_o,
  output logic       lost_o
);
  localparam int CW = $clog2(HOLD + 1);
  typedef enum logic {S_IDLE, S_HOLD} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d, dout_q, dout_d, fnum_q, fnum_d;
  logic [1:0]    grp_q, grp_d;
  logic [2:0]    sub_q, sub_d;
  logic [5:0]    up_q, up_d;
  logic          write_q, write_d, lost_q, lost_d, wr_n_q;
  logic          wr_edge, awr, dwr, op_ok, ch_ok, fn_ok, win;
  logic [5:0]    dec_up;
  logic [1:0]    dec_grp;
  logic [2:0]    dec_sub;
  assign wr_edge = !cs_n_i && wr_n_q && !wr_n_i;
  assign awr     = wr_edge && !addr_i;
  assign dwr     = wr_edge && addr_i;
  // Decode always reads the address register as it stands at the data write.
  assign op_ok   = addr_q[7:5] >= 3'd1 && addr_q[7:5] <= 3'd4 && addr_q[4:3] != 2'b11 && addr_q[2:0] < 3'd6;
  assign ch_ok   = (addr_q[7:4] == 4'hB || addr_q[7:4] == 4'hC) && addr_q[3:0] <= 4'd8;
  assign fn_ok   = addr_q[7:4] == 4'hA && addr_q[3:0] <= 4'd8;
  assign win     = dwr && (op_ok || ch_ok);
  assign dec_up  = op_ok ? 6'd1 << (addr_q[7:5] - 3'd1) : (addr_q[7:4] == 4'hB ? 6'b010000 : 6'b100000);
  assign dec_grp = op_ok ? addr_q[4:3] : 2'(addr_q[3:0] / 4'd3);
  assign dec_sub = op_ok ? addr_q[2:0] : 3'(addr_q[3:0] % 4'd3);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = awr ? din_i : addr_q;
    fnum_d  = (dwr && fn_ok) ? din_i : fnum_q;
    dout_d  = dout_q;
    grp_d   = grp_q;
    sub_d   = sub_q;
    up_d    = up_q;
    write_d = 1'b0;
    lost_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (win) begin
        state_d = S_HOLD;
        cnt_d   = CW'(HOLD);
        dout_d  = din_i;
        grp_d   = dec_grp;
        sub_d   = dec_sub;
        up_d    = dec_up;
        write_d = 1'b1;
      end
    end else begin
      lost_d = win;
      if (cen_i) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          up_d    = '0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      fnum_q  <= '0;
      dout_q  <= '0;
      grp_q   <= '0;
      sub_q   <= '0;
      up_q    <= '0;
      write_q <= 1'b0;
      lost_q  <= 1'b0;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      fnum_q  <= fnum_d;
      dout_q  <= dout_d;
      grp_q   <= grp_d;
      sub_q   <= sub_d;
      up_q    <= up_d;
      write_q <= write_d;
      lost_q  <= lost_d;
      wr_n_q  <= wr_n_i;
    end
  end
  assign dout_o       = dout_q;
  assign write_o      = write_q;
  assign sel_group_o  = grp_q;
  assign sel_sub_o    = sub_q;
  assign latch_fnum_o = fnum_q;
  assign busy_o       = state_q == S_HOLD;
  assign lost_o       = lost_q;
  assign {up_fbcon_o, up_fnum_o, up_sl_rr_o, up_ar_dr_o, up_ksl_tl_o, up_mult_o} = up_q;
endmodule

// File: tb/tb_jtopl_wr_ctrl.sv
// tb_jtopl_wr_ctrl: directed scenarios plus randomized writes compared against a
// behavioural model built from the register map and hold-window rules.
module tb_jtopl_wr_ctrl;
  logic clk = 0, rst_n = 0, cen = 0, cs_n = 1, wr_n = 1, addr = 0;
  logic [7:0] din = 0;
  logic [7:0] dout, latch_fnum;
  logic write, busy, lost, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic [5:0] dut_up;
  int checks = 0, errors = 0, cen_pct = 100;

  jtopl_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cen_i(cen), .cs_n_i(cs_n), .wr_n_i(wr_n), .addr_i(addr), .din_i(din),
    .dout_o(dout), .write_o(write), .sel_group_o(sel_group), .sel_sub_o(sel_sub),
    .up_mult_o(up_mult), .up_ksl_tl_o(up_ksl_tl), .up_ar_dr_o(up_ar_dr), .up_sl_rr_o(up_sl_rr),
    .up_fnum_o(up_fnum), .up_fbcon_o(up_fbcon), .latch_fnum_o(latch_fnum), .busy_o(busy), .lost_o(lost)
  );
  assign dut_up = {up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    cen = $urandom_range(99) < cen_pct;
  end

  // Register map as arithmetic: strobe index (-1 = no window), group, subslot.
  function automatic int up_of(input logic [7:0] a);
    if (a >= 8'h20 && a < 8'hA0) return ((a % 32) / 8 < 3 && a % 8 < 6) ? a / 32 - 1 : -1;
    if ((a / 16 == 11 || a / 16 == 12) && a % 16 <= 8) return a / 16 == 11 ? 4 : 5;
    return -1;
  endfunction
  function automatic int grp_of(input logic [7:0] a);
    return a < 8'hA0 ? (a % 32) / 8 : (a % 16) / 3;
  endfunction
  function automatic int sub_of(input logic [7:0] a);
    return a < 8'hA0 ? a % 8 : (a % 16) % 3;
  endfunction
  function automatic logic [5:0] vec(input int u);
    return u < 0 ? 6'd0 : 6'(1 << u);
  endfunction

  logic m_prev, m_write, m_lost;
  logic [7:0] m_addr, m_dout, m_fnum;
  int m_left, m_up, m_grp, m_sub;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 1; m_addr <= 0; m_left <= 0; m_up <= -1; m_grp <= 0; m_sub <= 0;
      m_dout <= 0; m_fnum <= 0; m_write <= 0; m_lost <= 0;
    end else begin
      m_prev <= wr_n; m_write <= 0; m_lost <= 0;
      if (m_left > 0 && cen) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_up <= -1;
      end
      if (!cs_n && m_prev && !wr_n) begin
        if (!addr) m_addr <= din;
        else begin
          if (m_addr / 16 == 10 && m_addr % 16 <= 8) m_fnum <= din;
          if (up_of(m_addr) >= 0) begin
            if (m_left == 0) begin
              m_left <= 21; m_up <= up_of(m_addr); m_grp <= grp_of(m_addr); m_sub <= sub_of(m_addr);
              m_dout <= din; m_write <= 1;
            end else m_lost <= 1;
          end
        end
      end
    end
  end

  task automatic cpu_wr(input logic a, input logic [7:0] d);
    @(negedge clk); cs_n = 0; addr = a; din = d; wr_n = 0;
    @(negedge clk); wr_n = 1; cs_n = 1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); #1; n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s timeout busy=%b want 0", tag, busy); end
  endtask

  task automatic test_reset;
    cen_pct = 100; rst_n = 0;
    repeat (3) @(negedge clk); #1;
    checks++; if ({dout, write, sel_group, sel_sub, dut_up, latch_fnum, busy, lost} !== 31'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {dout, write, sel_group, sel_sub, dut_up, latch_fnum, busy, lost}); end
    rst_n = 1;
    cpu_wr(0, 8'h43); cpu_wr(1, 8'hAA); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    repeat (4) @(negedge clk); #2; rst_n = 0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (dut_up !== 6'd0) begin errors++; $display("FAIL midreset_up got %b want 0", dut_up); end
    checks++; if ({dout, sel_group, sel_sub} !== 13'd0) begin errors++; $display("FAIL midreset_target got %h want 0", {dout, sel_group, sel_sub}); end
    @(negedge clk); rst_n = 1;
    cpu_wr(0, 8'h88); cpu_wr(1, 8'h66); #1;
    checks++; if (dut_up !== 6'b001000) begin errors++; $display("FAIL postreset_up got %b want 001000", dut_up); end
    checks++; if ({write, busy, sel_group, sel_sub, dout} !== {1'b1, 1'b1, 2'd1, 3'd0, 8'h66}) begin
      errors++; $display("FAIL postreset_target got %h want %h", {write, busy, sel_group, sel_sub, dout}, {1'b1, 1'b1, 2'd1, 3'd0, 8'h66}); end
    wait_idle("postreset_idle");
  endtask

  task automatic test_op_write;
    int ticks = 0, writes = 1, n = 0;
    cen_pct = 70;
    cpu_wr(0, 8'h43); cpu_wr(1, 8'h3F); #1;
    checks++; if (dut_up !== 6'b000010) begin errors++; $display("FAIL op_up got %b want 000010", dut_up); end
    checks++; if ({sel_group, sel_sub, dout, write, busy} !== {2'd0, 3'd3, 8'h3F, 1'b1, 1'b1}) begin
      errors++; $display("FAIL op_target got %h want %h", {sel_group, sel_sub, dout, write, busy}, {2'd0, 3'd3, 8'h3F, 1'b1, 1'b1}); end
    while (busy && n < 1000) begin
      if (cen) ticks++;
      @(negedge clk); #1; n++;
      if (write) writes++;
    end
    checks++; if (ticks != 21) begin errors++; $display("FAIL op_ticks got %0d want 21", ticks); end
    checks++; if (writes != 1) begin errors++; $display("FAIL op_write_pulses got %0d want 1", writes); end
    checks++; if ({busy, dut_up} !== 7'd0) begin errors++; $display("FAIL op_end got %b want 0", {busy, dut_up}); end
    checks++; if ({sel_group, sel_sub, dout} !== {2'd0, 3'd3, 8'h3F}) begin errors++; $display("FAIL op_retain got %h want %h", {sel_group, sel_sub, dout}, {2'd0, 3'd3, 8'h3F}); end
  endtask

  task automatic test_ignored;
    logic [7:0] list [8] = '{8'h26, 8'h3E, 8'h9F, 8'hA9, 8'hB9, 8'h00, 8'hFF, 8'h1F};
    cen_pct = 100;
    foreach (list[i]) begin
      cpu_wr(0, list[i]); cpu_wr(1, 8'h11); #1;
      checks++; if ({busy, lost, write, dut_up} !== 9'd0) begin errors++; $display("FAIL ignored_%h got %b want 0", list[i], {busy, lost, write, dut_up}); end
      checks++; if (dout !== 8'h3F) begin errors++; $display("FAIL ignored_dout_%h got %h want 3f", list[i], dout); end
    end
  endtask

  task automatic test_fnum_chan;
    cen_pct = 100;
    cpu_wr(0, 8'hA5); cpu_wr(1, 8'h81); #1;
    checks++; if ({latch_fnum, busy} !== {8'h81, 1'b0}) begin errors++; $display("FAIL fnum_latch got %h want %h", {latch_fnum, busy}, {8'h81, 1'b0}); end
    cpu_wr(0, 8'hB5); cpu_wr(1, 8'h32); #1;
    checks++; if (dut_up !== 6'b010000) begin errors++; $display("FAIL chan_up got %b want 010000", dut_up); end
    checks++; if ({sel_group, sel_sub, dout, busy} !== {2'd1, 3'd2, 8'h32, 1'b1}) begin
      errors++; $display("FAIL chan_target got %h want %h", {sel_group, sel_sub, dout, busy}, {2'd1, 3'd2, 8'h32, 1'b1}); end
    wait_idle("chan_idle");
  endtask

  task automatic test_back_to_back;
    cen_pct = 0;
    cpu_wr(0, 8'hC7); cpu_wr(1, 8'h05); #1;
    checks++; if ({dut_up, sel_group, sel_sub} !== {6'b100000, 2'd2, 3'd1}) begin errors++; $display("FAIL fbcon_target got %h want %h", {dut_up, sel_group, sel_sub}, {6'b100000, 2'd2, 3'd1}); end
    cpu_wr(0, 8'h62); cpu_wr(1, 8'h10); #1;
    checks++; if ({lost, write} !== 2'b10) begin errors++; $display("FAIL lost_pulse got %b want 10", {lost, write}); end
    checks++; if ({dut_up, sel_group, sel_sub, dout} !== {6'b100000, 2'd2, 3'd1, 8'h05}) begin
      errors++; $display("FAIL lost_unchanged got %h want %h", {dut_up, sel_group, sel_sub, dout}, {6'b100000, 2'd2, 3'd1, 8'h05}); end
    cpu_wr(0, 8'hA2); cpu_wr(1, 8'h77); #1;
    checks++; if ({latch_fnum, lost, busy} !== {8'h77, 1'b0, 1'b1}) begin errors++; $display("FAIL fnum_in_window got %h want %h", {latch_fnum, lost, busy}, {8'h77, 1'b0, 1'b1}); end
    cen_pct = 100;
    wait_idle("b2b_idle");
  endtask

  task automatic test_cen_stall;
    int ticks = 0, n = 0;
    cen_pct = 100;
    cpu_wr(0, 8'h8D); cpu_wr(1, 8'h5A); #1;
    checks++; if ({dut_up, sel_group, sel_sub} !== {6'b001000, 2'd1, 3'd5}) begin errors++; $display("FAIL stall_target got %h want %h", {dut_up, sel_group, sel_sub}, {6'b001000, 2'd1, 3'd5}); end
    while (busy && n < 500) begin
      if (cen) ticks++;
      @(negedge clk); #1; n++;
      if (n == 10) cen_pct = 0;
      if (n == 62) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", busy); end
        cen_pct = 100;
      end
    end
    checks++; if (ticks != 21 || busy !== 1'b0) begin errors++; $display("FAIL stall_ticks got %0d/%b want 21/0", ticks, busy); end
  endtask

  task automatic test_random;
    logic [7:0] a;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) cen_pct = $urandom_range(20, 100);
      case ($urandom_range(3))
        0: a = 8'h20 + 8'($urandom_range(127));
        1: a = {4'($urandom_range(10, 12)), 4'($urandom_range(9))};
        default: a = 8'($urandom);
      endcase
      if ($urandom_range(2) == 0) cpu_wr(0, a);
      cpu_wr(1, 8'($urandom)); #1;
      checks++; if ({dout, sel_group, sel_sub, dut_up, latch_fnum, busy, write, lost} !==
                    {m_dout, 2'(m_grp), 3'(m_sub), vec(m_up), m_fnum, m_left > 0, m_write, m_lost}) begin
        errors++; $display("FAIL random_%0d got %h want %h", i, {dout, sel_group, sel_sub, dut_up, latch_fnum, busy, write, lost},
                           {m_dout, 2'(m_grp), 3'(m_sub), vec(m_up), m_fnum, m_left > 0, m_write, m_lost}); end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_op_write();
    test_ignored();
    test_fnum_chan();
    test_back_to_back();
    test_cen_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
